// File: rtl/bird_physics_if.sv
// rtl/bird_physics_if.sv - game-control bundle between game_fsm/input path and bird_physics
// master drives state, tick, mouse and pipe geometry; slave returns bird_y, collision, score_pulse.
interface bird_physics_if;
  logic [1:0]  state;
  logic        frame_tick;
  logic        mouse_left;
  logic [10:0] pipe_x;
  logic [9:0]  pipe_gap_y;
  logic [9:0]  bird_y;
  logic        collision;
  logic        score_pulse;

  modport master (
    output state, frame_tick, mouse_left, pipe_x, pipe_gap_y,
    input  bird_y, collision, score_pulse
  );

  modport slave (
    input  state, frame_tick, mouse_left, pipe_x, pipe_gap_y,
    output bird_y, collision, score_pulse
  );
endinterface

// File: rtl/bird_physics.sv
// rtl/bird_physics.sv - per-frame bird vertical motion, collision and score pulse
// Optional BIRD_GODMODE_EN removes the pipe-hit term; ceiling/ground and scoring remain.
module bird_physics #(
  parameter int BIRD_X    = 200,
  parameter int BIRD_SIZE = 32,
  parameter int PIPE_W    = 64,
  parameter int GAP_H     = 160,
  parameter int SCREEN_H  = 600,
  parameter int START_Y   = 284,
  parameter int GRAVITY   = 1,
  parameter int FLAP_VEL  = -10,
  parameter int VMAX      = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bird_physics_if.slave io_bus
);

  typedef enum logic [1:0] {
    MODE_START = 2'b00,
    MODE_GAME  = 2'b01,
    MODE_OVER  = 2'b10,
    MODE_ALT   = 2'b11
  } mode_t;

  localparam logic signed [11:0] C_ZERO  = 12'sd0;
  localparam logic signed [11:0] C_FLAP  = 12'(FLAP_VEL);
  localparam logic signed [11:0] C_GRAV  = 12'(GRAVITY);
  localparam logic signed [11:0] C_VMAX  = 12'(VMAX);
  localparam logic signed [11:0] C_Y_MAX = 12'(SCREEN_H - BIRD_SIZE);

  localparam logic [12:0] C_BIRD_X = 13'(BIRD_X);
  localparam logic [12:0] C_BIRD_R = 13'(BIRD_X + BIRD_SIZE);
  localparam logic [12:0] C_PIPE_W = 13'(PIPE_W);

  localparam logic [9:0] C_START_Y = 10'(START_Y);

  logic              r_mouse_d;
  logic              r_flap_pending;
  logic signed [5:0] r_vel;
  logic [9:0]        r_bird_y;
  logic              r_collision;
  logic              r_score_pulse;
  logic              r_passed;

  mode_t              w_mode;
  logic               w_in_game;
  logic               w_in_over;
  logic               w_flap_edge;
  logic signed [11:0] w_vel_ext;
  logic signed [11:0] w_vel_inc;
  logic signed [11:0] w_vel_n;
  logic signed [11:0] w_y_sum;
  logic signed [11:0] w_y_n;
  logic               w_hit_ceil;
  logic               w_hit_ground;
  logic               w_pipe_hit;
  logic               w_hit;
  logic [12:0]        w_px;
  logic               w_crossed;
  logic               w_new_pipe;

  assign w_mode      = mode_t'(io_bus.state);
  assign w_in_game   = (w_mode == MODE_GAME);
  assign w_in_over   = (w_mode == MODE_OVER);
  assign w_flap_edge = io_bus.mouse_left & ~r_mouse_d;

  // Velocity and position are evaluated in signed 12-bit so the ceiling overshoot stays visible.
  always_comb begin
    w_vel_ext = {{6{r_vel[5]}}, r_vel};
    w_vel_inc = w_vel_ext + C_GRAV;
    w_vel_n   = w_vel_inc;
    if (r_flap_pending) begin
      w_vel_n = C_FLAP;
    end else if (w_vel_inc > C_VMAX) begin
      w_vel_n = C_VMAX;
    end

    w_y_sum = signed'({2'b00, r_bird_y}) + w_vel_n;
    w_y_n   = w_y_sum;
    if (w_y_sum < C_ZERO) begin
      w_y_n = C_ZERO;
    end else if (w_y_sum > C_Y_MAX) begin
      w_y_n = C_Y_MAX;
    end
  end

  assign w_hit_ceil   = (w_y_sum <= C_ZERO);
  assign w_hit_ground = (w_y_sum >= C_Y_MAX);

  assign w_px       = {2'b00, io_bus.pipe_x};
  assign w_crossed  = ((w_px + C_PIPE_W) < C_BIRD_X);
  assign w_new_pipe = (w_px >= C_BIRD_R);

`ifdef BIRD_GODMODE_EN
  assign w_pipe_hit = 1'b0;
`else
  localparam logic [12:0] C_BIRD_SZ = 13'(BIRD_SIZE);
  localparam logic [12:0] C_GAP_H   = 13'(GAP_H);

  logic [12:0] w_y_u;
  logic [12:0] w_gap_u;
  logic        w_overlap;
  logic        w_outside_gap;

  // w_y_n is clamped non-negative, so a zero-extended view is safe for the unsigned compares.
  assign w_y_u         = {1'b0, w_y_n};
  assign w_gap_u       = {3'b000, io_bus.pipe_gap_y};
  assign w_overlap     = (w_px < C_BIRD_R) && ((w_px + C_PIPE_W) > C_BIRD_X);
  assign w_outside_gap = (w_y_u < w_gap_u) || ((w_y_u + C_BIRD_SZ) > (w_gap_u + C_GAP_H));
  assign w_pipe_hit    = w_overlap & w_outside_gap;
`endif

  assign w_hit = w_hit_ceil | w_hit_ground | w_pipe_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mouse_d      <= 1'b0;
      r_flap_pending <= 1'b0;
      r_vel          <= '0;
      r_bird_y       <= C_START_Y;
      r_collision    <= 1'b0;
      r_score_pulse  <= 1'b0;
      r_passed       <= 1'b0;
    end else begin
      r_mouse_d     <= io_bus.mouse_left;
      r_score_pulse <= 1'b0;
      if (w_in_game) begin
        // A click landing on the tick itself is kept for the following frame.
        r_flap_pending <= io_bus.frame_tick ? w_flap_edge : (r_flap_pending | w_flap_edge);
        if (io_bus.frame_tick) begin
          r_vel    <= w_vel_n[5:0];
          r_bird_y <= w_y_n[9:0];
          if (w_hit) begin
            r_collision <= 1'b1;
          end else if (w_crossed && !r_passed) begin
            r_score_pulse <= 1'b1;
            r_passed      <= 1'b1;
          end
          if (w_new_pipe) begin
            r_passed <= 1'b0;
          end
        end
      end else if (w_in_over) begin
        r_flap_pending <= 1'b0;
      end else begin
        r_flap_pending <= 1'b0;
        r_vel          <= '0;
        r_bird_y       <= C_START_Y;
        r_collision    <= 1'b0;
        r_passed       <= 1'b0;
      end
    end
  end

  assign io_bus.bird_y      = r_bird_y;
  assign io_bus.collision   = r_collision;
  assign io_bus.score_pulse = r_score_pulse;

endmodule

// File: tb/tb_bird_physics.sv
// tb/tb_bird_physics.sv - directed vector table plus randomized run against a frame-level model
module tb_bird_physics;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bird_physics_if bus ();

  bird_physics dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  typedef struct {
    string      nm;
    bit         r;
    logic [1:0] st;
    bit         tk;
    bit         ms;
    int         px;
    int         gy;
    bit         chk;
    int         ey;
    bit         ec;
    bit         es;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  int m_y, m_vel;
  bit m_coll, m_score, m_pend, m_passed, m_md;

  function automatic void add(string nm, bit r, logic [1:0] st, bit tk, bit ms, int px, int gy,
                              bit chk, int ey, bit ec, bit es);
    vec_t v;
    v.nm = nm; v.r = r; v.st = st; v.tk = tk; v.ms = ms; v.px = px; v.gy = gy;
    v.chk = chk; v.ey = ey; v.ec = ec; v.es = es;
    vecs.push_back(v);
  endfunction

  // Frame-level reference: plain integer arithmetic straight from the game rules.
  task automatic model_cycle(input bit r, input logic [1:0] st, input bit tk, input bit ms,
                             input int px, input int gy);
    int vn, yn;
    bit hit, fe;
    fe = ms && !m_md;
    if (r) begin
      m_y = 284; m_vel = 0; m_coll = 0; m_score = 0; m_pend = 0; m_passed = 0; m_md = 0;
    end else begin
      m_md = ms;
      m_score = 0;
      if (st == 2'b01) begin
        if (tk) begin
          vn  = m_pend ? -10 : ((m_vel + 1 > 12) ? 12 : m_vel + 1);
          yn  = m_y + vn;
          hit = (yn <= 0) || (yn >= 568);
          yn  = (yn < 0) ? 0 : ((yn > 568) ? 568 : yn);
`ifndef BIRD_GODMODE_EN
          if ((px < 232) && (px + 64 > 200) && ((yn < gy) || (yn + 32 > gy + 160))) hit = 1;
`endif
          m_y = yn;
          m_vel = vn;
          if (hit) m_coll = 1;
          else if ((px + 64 < 200) && !m_passed) begin
            m_score = 1;
            m_passed = 1;
          end
          if (px >= 232) m_passed = 0;
          m_pend = fe;
        end else begin
          m_pend = m_pend || fe;
        end
      end else if (st == 2'b10) begin
        m_pend = 0;
      end else begin
        m_y = 284; m_vel = 0; m_coll = 0; m_pend = 0; m_passed = 0;
      end
    end
  endtask

  task automatic apply_cycle(input bit r, input logic [1:0] st, input bit tk, input bit ms,
                             input int px, input int gy);
    rst = r;
    bus.state = st;
    bus.frame_tick = tk;
    bus.mouse_left = ms;
    bus.pipe_x = px[10:0];
    bus.pipe_gap_y = gy[9:0];
    @(posedge clk);
    #1;
    model_cycle(r, st, tk, ms, px, gy);
  endtask

  task automatic check(input string nm, input int ey, input bit ec, input bit es);
    n_total++;
    if (int'(bus.bird_y) == ey && bus.collision == ec && bus.score_pulse == es) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got y=%0d c=%0d s=%0d, want y=%0d c=%0d s=%0d",
               nm, bus.bird_y, bus.collision, bus.score_pulse, ey, ec, es);
    end
  endtask

  initial begin
    int y;
    int st_r;
    logic [1:0] st;
    bit pipe_exp;

`ifdef BIRD_GODMODE_EN
    pipe_exp = 0;
`else
    pipe_exp = 1;
`endif

    // Reset, then START with mouse toggling; first GAME tick must be plain gravity.
    add("reset",        1, 2'b01, 1, 1, 1000, 200, 1, 284, 0, 0);
    add("start_m1",     0, 2'b00, 0, 1, 1000, 200, 1, 284, 0, 0);
    add("start_m0",     0, 2'b00, 1, 0, 1000, 200, 1, 284, 0, 0);
    add("start_m1b",    0, 2'b11, 0, 1, 1000, 200, 1, 284, 0, 0);
    add("start_m0b",    0, 2'b00, 0, 0, 1000, 200, 1, 284, 0, 0);

    // Free fall to the ground.
    for (int k = 1; k <= 30; k++) begin
      case (k)
        1:  add("fall_t1",  0, 2'b01, 1, 0, 1000, 200, 1, 285, 0, 0);
        2:  add("fall_t2",  0, 2'b01, 1, 0, 1000, 200, 1, 287, 0, 0);
        3:  add("fall_t3",  0, 2'b01, 1, 0, 1000, 200, 1, 290, 0, 0);
        12: add("fall_t12", 0, 2'b01, 1, 0, 1000, 200, 1, 362, 0, 0);
        29: add("fall_t29", 0, 2'b01, 1, 0, 1000, 200, 1, 566, 0, 0);
        30: add("fall_t30", 0, 2'b01, 1, 0, 1000, 200, 1, 568, 1, 0);
        default: add("fall", 0, 2'b01, 1, 0, 1000, 200, 0, 0, 0, 0);
      endcase
      if (k == 3) add("fall_hold", 0, 2'b01, 0, 0, 1000, 200, 1, 290, 0, 0);
    end
    add("ground_hold",  0, 2'b01, 0, 0, 1000, 200, 1, 568, 1, 0);
    add("over_a",       0, 2'b10, 1, 1, 1000, 200, 1, 568, 1, 0);
    add("over_b",       0, 2'b10, 1, 0, 1000, 200, 1, 568, 1, 0);
    add("over_c",       0, 2'b10, 1, 1, 100,  200, 1, 568, 1, 0);
    add("over_start",   0, 2'b00, 0, 0, 1000, 200, 1, 284, 0, 0);

    // Flap, then a click coincident with the tick.
    add("flap_click",   0, 2'b01, 0, 1, 1000, 200, 1, 284, 0, 0);
    add("flap_t1",      0, 2'b01, 1, 0, 1000, 200, 1, 274, 0, 0);
    add("flap_t2",      0, 2'b01, 1, 0, 1000, 200, 1, 265, 0, 0);
    add("coinc_tick",   0, 2'b01, 1, 1, 1000, 200, 1, 257, 0, 0);
    add("coinc_next",   0, 2'b01, 1, 0, 1000, 200, 1, 247, 0, 0);

    // Pipe overlap at y=285: narrow gap hits, wide gap clears.
    add("pipe_rst",     0, 2'b00, 0, 0, 1000, 200, 1, 284, 0, 0);
    add("pipe_hit",     0, 2'b01, 1, 0, 180,  100, 1, 285, pipe_exp, 0);
    add("pipe_rst2",    0, 2'b00, 0, 0, 1000, 200, 1, 284, 0, 0);
    add("pipe_gap_ok",  0, 2'b01, 1, 0, 180,  250, 1, 285, 0, 0);

    // Score crossing, once per pipe.
    add("score_rst",    0, 2'b00, 0, 0, 1000, 200, 1, 284, 0, 0);
    add("score_140",    0, 2'b01, 1, 0, 140,  200, 1, 285, 0, 0);
    add("score_135",    0, 2'b01, 1, 0, 135,  200, 1, 287, 0, 1);
    add("score_idle",   0, 2'b01, 0, 0, 135,  200, 1, 287, 0, 0);
    add("score_130",    0, 2'b01, 1, 0, 130,  200, 1, 290, 0, 0);
    add("score_800",    0, 2'b01, 1, 0, 800,  200, 1, 294, 0, 0);
    add("score_135b",   0, 2'b01, 1, 0, 135,  200, 1, 299, 0, 1);

    // Ceiling by repeated flaps.
    add("ceil_rst",     0, 2'b00, 0, 0, 1000, 200, 1, 284, 0, 0);
    for (int k = 1; k <= 29; k++) begin
      add("ceil_click", 0, 2'b01, 0, 1, 1000, 200, 0, 0, 0, 0);
      if (k == 29) add("ceil_hit", 0, 2'b01, 1, 0, 1000, 200, 1, 0, 1, 0);
      else if (k == 1 || k == 28) add("ceil_step", 0, 2'b01, 1, 0, 1000, 200, 1, 284 - 10 * k, 0, 0);
      else add("ceil_step", 0, 2'b01, 1, 0, 1000, 200, 0, 0, 0, 0);
    end
    add("ceil_start",   0, 2'b00, 0, 0, 1000, 200, 1, 284, 0, 0);

    foreach (vecs[i]) begin
      apply_cycle(vecs[i].r, vecs[i].st, vecs[i].tk, vecs[i].ms, vecs[i].px, vecs[i].gy);
      if (vecs[i].chk) check(vecs[i].nm, vecs[i].ey, vecs[i].ec, vecs[i].es);
    end

    // Randomized run against the model.
    apply_cycle(1, 2'b00, 0, 0, 1000, 200);
    check("rand_reset", m_y, m_coll, m_score);
    st = 2'b01;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        st_r = $urandom_range(0, 9);
        st = (st_r < 6) ? 2'b01 : (st_r < 8) ? 2'b00 : (st_r < 9) ? 2'b10 : 2'b11;
      end
      apply_cycle($urandom_range(0, 299) == 0, st, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1100), $urandom_range(0, 440));
      check("rand", m_y, m_coll, m_score);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
